ppdu_framer: RTL

Parametrised 802.11a PPDU framer: serialises preamble, SIGNAL field and scrambled DATA field one bit per clock, with RATE and LENGTH supplied per frame at Start rather than fixed at build time. Rate-dependent pad-bit computation (N_DBPS decoded from RATE), a valid/ready PSDU input with stall support, an illegal-field error path, and unscrambled DATA tail bits are included. Sits at the head of the transmit chain, feeding the convolutional encoder through Output/OutputValid.

---
 rtl/ppdu_pkg.sv | 49 ++++
 rtl/ppdu_scrambler.sv | 32 +++
 rtl/ppdu_framer.sv | 244 ++++++++++++++++++++++++
 3 files changed

// File: rtl/ppdu_pkg.sv
// Shared types and helpers for the 802.11a PPDU framer: frame states,
// SIGNAL/SERVICE field widths, RATE decoding and SIGNAL parity.
package ppdu_pkg;

  typedef enum logic [3:0] {
    ST_IDLE       = 4'd0,
    ST_PREAMBLE   = 4'd1,
    ST_SIG_RATE   = 4'd2,
    ST_SIG_RSVD   = 4'd3,
    ST_SIG_LENGTH = 4'd4,
    ST_SIG_PARITY = 4'd5,
    ST_SIG_TAIL   = 4'd6,
    ST_SERVICE    = 4'd7,
    ST_PSDU       = 4'd8,
    ST_DATA_TAIL  = 4'd9,
    ST_PAD        = 4'd10
  } state_e;

  localparam int unsigned RATE_BITS      = 4;
  localparam int unsigned LENGTH_BITS    = 12;
  localparam int unsigned SIG_TAIL_BITS  = 6;
  localparam int unsigned SERVICE_BITS   = 16;
  localparam int unsigned DATA_TAIL_BITS = 6;

  // Data bits per OFDM symbol; zero marks a RATE code that is not defined.
  function automatic logic [7:0] rate_to_ndbps(input logic [3:0] rate);
    case (rate)
      4'b1101: return 8'd24;
      4'b1111: return 8'd36;
      4'b0101: return 8'd48;
      4'b0111: return 8'd72;
      4'b1001: return 8'd96;
      4'b1011: return 8'd144;
      4'b0001: return 8'd192;
      4'b0011: return 8'd216;
      default: return 8'd0;
    endcase
  endfunction

  function automatic logic rate_illegal(input logic [3:0] rate);
    return (rate_to_ndbps(rate) == 8'd0);
  endfunction

  // Even parity over RATE, the reserved zero bit and LENGTH.
  function automatic logic signal_parity(input logic [3:0] rate, input logic [11:0] length);
    return ^{rate, 1'b0, length};
  endfunction

endpackage

// File: rtl/ppdu_scrambler.sv
// 802.11a data scrambler, x^7 + x^4 + 1; output is combinational from the
// current LFSR state so the scrambled bit can be registered by the framer.
module ppdu_scrambler (
  input  logic       Clock,
  input  logic       Reset,
  input  logic       load,
  input  logic [6:0] seed,
  input  logic       enable,
  input  logic       data_in,
  output logic       data_out
);

  logic [6:0] lfsr_r;
  logic       feedback_s;

  assign feedback_s = lfsr_r[6] ^ lfsr_r[3];
  assign data_out   = data_in ^ feedback_s;

  // LFSR state: load wins over advance
  always_ff @(posedge Clock) begin
    if (Reset) begin
      lfsr_r <= 7'd0;
    end else if (load) begin
      lfsr_r <= seed;
    end else if (enable) begin
      lfsr_r <= {lfsr_r[5:0], feedback_s};
    end else begin
      lfsr_r <= lfsr_r;
    end
  end

endmodule

// File: rtl/ppdu_framer.sv
// 802.11a PPDU framer: serialises preamble, SIGNAL and scrambled DATA one bit
// per clock, with RATE/LENGTH latched per frame and a stallable PSDU input.
module ppdu_framer
  import ppdu_pkg::*;
#(
  parameter int unsigned PREAMBLE_BITS  = 96,
  parameter logic [6:0]  SCRAMBLER_SEED = 7'b1011101
) (
  input  logic        Clock,
  input  logic        Reset,
  input  logic        Start,
  input  logic [3:0]  Rate,
  input  logic [11:0] Length,
  input  logic        Input,
  input  logic        InputValid,
  output logic        InputReady,
  output logic        Output,
  output logic        OutputValid,
  output logic        Busy,
  output logic        Done,
  output logic        Error
);

  localparam logic [14:0] PRE_LAST     = 15'(PREAMBLE_BITS - 1);
  localparam logic [14:0] RATE_LAST    = 15'(RATE_BITS - 1);
  localparam logic [14:0] LENGTH_LAST  = 15'(LENGTH_BITS - 1);
  localparam logic [14:0] SIGTAIL_LAST = 15'(SIG_TAIL_BITS - 1);
  localparam logic [14:0] SERVICE_LAST = 15'(SERVICE_BITS - 1);
  localparam logic [14:0] DTAIL_LAST   = 15'(DATA_TAIL_BITS - 1);

  state_e      state_r, state_n;
  logic [14:0] cnt_r, cnt_n;
  logic [7:0]  sym_r, sym_n, sym_next_s, ndbps_r;
  logic [3:0]  rate_r, rate_sh_s;
  logic [11:0] length_r, length_sh_s;
  logic [14:0] psdu_last_s;
  logic        sym_wrap_s;
  logic        out_bit_r, out_valid_r, busy_r, done_r, error_r;
  logic        emit_valid_s, raw_bit_s, use_scr_s, emit_bit_s, last_s, err_s;
  logic        load_fields_s, scr_load_s, scr_en_s, scr_out_s;

  assign rate_sh_s   = rate_r << cnt_r[1:0];
  assign length_sh_s = length_r >> cnt_r[3:0];
  assign psdu_last_s = {length_r, 3'b000} - 15'd1;
  assign sym_wrap_s  = (sym_r == (ndbps_r - 8'd1));
  assign sym_next_s  = sym_wrap_s ? 8'd0 : (sym_r + 8'd1);
  assign emit_bit_s  = use_scr_s ? scr_out_s : raw_bit_s;
  assign InputReady  = (state_r == ST_PSDU);

  ppdu_scrambler u_scrambler (
    .Clock    (Clock),
    .Reset    (Reset),
    .load     (scr_load_s),
    .seed     (SCRAMBLER_SEED),
    .enable   (scr_en_s),
    .data_in  (raw_bit_s),
    .data_out (scr_out_s)
  );

  // Next state, field counters and the bit emitted this cycle
  always_comb begin
    state_n       = state_r;
    cnt_n         = cnt_r;
    sym_n         = sym_r;
    emit_valid_s  = 1'b0;
    raw_bit_s     = 1'b0;
    use_scr_s     = 1'b0;
    scr_en_s      = 1'b0;
    scr_load_s    = 1'b0;
    load_fields_s = 1'b0;
    last_s        = 1'b0;
    err_s         = 1'b0;
    case (state_r)
      ST_IDLE: begin
        if (Start) begin
          if (rate_illegal(Rate) || (Length == 12'd0)) begin
            err_s = 1'b1;
          end else begin
            // first preamble bit leaves on the same edge that accepts Start
            load_fields_s = 1'b1;
            emit_valid_s  = 1'b1;
            raw_bit_s     = 1'b1;
            state_n       = ST_PREAMBLE;
            cnt_n         = 15'd1;
          end
        end else begin
          state_n = ST_IDLE;
        end
      end
      ST_PREAMBLE: begin
        emit_valid_s = 1'b1;
        raw_bit_s    = ~cnt_r[0];
        if (cnt_r == PRE_LAST) begin
          state_n = ST_SIG_RATE;
          cnt_n   = 15'd0;
        end else begin
          cnt_n = cnt_r + 15'd1;
        end
      end
      ST_SIG_RATE: begin
        emit_valid_s = 1'b1;
        raw_bit_s    = rate_sh_s[3];
        if (cnt_r == RATE_LAST) begin
          state_n = ST_SIG_RSVD;
          cnt_n   = 15'd0;
        end else begin
          cnt_n = cnt_r + 15'd1;
        end
      end
      ST_SIG_RSVD: begin
        emit_valid_s = 1'b1;
        state_n      = ST_SIG_LENGTH;
        cnt_n        = 15'd0;
      end
      ST_SIG_LENGTH: begin
        emit_valid_s = 1'b1;
        raw_bit_s    = length_sh_s[0];
        if (cnt_r == LENGTH_LAST) begin
          state_n = ST_SIG_PARITY;
          cnt_n   = 15'd0;
        end else begin
          cnt_n = cnt_r + 15'd1;
        end
      end
      ST_SIG_PARITY: begin
        emit_valid_s = 1'b1;
        raw_bit_s    = signal_parity(rate_r, length_r);
        state_n      = ST_SIG_TAIL;
        cnt_n        = 15'd0;
      end
      ST_SIG_TAIL: begin
        emit_valid_s = 1'b1;
        if (cnt_r == SIGTAIL_LAST) begin
          state_n    = ST_SERVICE;
          cnt_n      = 15'd0;
          sym_n      = 8'd0;
          scr_load_s = 1'b1;
        end else begin
          cnt_n = cnt_r + 15'd1;
        end
      end
      ST_SERVICE: begin
        emit_valid_s = 1'b1;
        use_scr_s    = 1'b1;
        scr_en_s     = 1'b1;
        sym_n        = sym_next_s;
        if (cnt_r == SERVICE_LAST) begin
          state_n = ST_PSDU;
          cnt_n   = 15'd0;
        end else begin
          cnt_n = cnt_r + 15'd1;
        end
      end
      ST_PSDU: begin
        if (InputValid) begin
          emit_valid_s = 1'b1;
          raw_bit_s    = Input;
          use_scr_s    = 1'b1;
          scr_en_s     = 1'b1;
          sym_n        = sym_next_s;
          if (cnt_r == psdu_last_s) begin
            state_n = ST_DATA_TAIL;
            cnt_n   = 15'd0;
          end else begin
            cnt_n = cnt_r + 15'd1;
          end
        end else begin
          state_n = ST_PSDU;
        end
      end
      ST_DATA_TAIL: begin
        // tail stays zero on the line but the scrambler keeps stepping
        emit_valid_s = 1'b1;
        scr_en_s     = 1'b1;
        sym_n        = sym_next_s;
        if (cnt_r == DTAIL_LAST) begin
          cnt_n = 15'd0;
          if (sym_wrap_s) begin
            state_n = ST_IDLE;
            last_s  = 1'b1;
          end else begin
            state_n = ST_PAD;
          end
        end else begin
          cnt_n = cnt_r + 15'd1;
        end
      end
      ST_PAD: begin
        emit_valid_s = 1'b1;
        use_scr_s    = 1'b1;
        scr_en_s     = 1'b1;
        sym_n        = sym_next_s;
        if (sym_wrap_s) begin
          state_n = ST_IDLE;
          last_s  = 1'b1;
        end else begin
          state_n = ST_PAD;
        end
      end
      default: begin
        state_n = ST_IDLE;
        cnt_n   = 15'd0;
      end
    endcase
  end

  // State, counters, latched frame fields and registered outputs
  always_ff @(posedge Clock) begin
    if (Reset) begin
      state_r     <= ST_IDLE;
      cnt_r       <= 15'd0;
      sym_r       <= 8'd0;
      rate_r      <= 4'd0;
      length_r    <= 12'd0;
      ndbps_r     <= 8'd0;
      out_bit_r   <= 1'b0;
      out_valid_r <= 1'b0;
      busy_r      <= 1'b0;
      done_r      <= 1'b0;
      error_r     <= 1'b0;
    end else begin
      state_r <= state_n;
      cnt_r   <= cnt_n;
      sym_r   <= sym_n;
      if (load_fields_s) begin
        rate_r   <= Rate;
        length_r <= Length;
        ndbps_r  <= rate_to_ndbps(Rate);
      end
      out_bit_r   <= emit_valid_s & emit_bit_s;
      out_valid_r <= emit_valid_s;
      busy_r      <= (state_n != ST_IDLE) || last_s;
      done_r      <= last_s;
      error_r     <= err_s;
    end
  end

  assign Output      = out_bit_r;
  assign OutputValid = out_valid_r;
  assign Busy        = busy_r;
  assign Done        = done_r;
  assign Error       = error_r;

endmodule
